block_xfer_sequencer: RTL and testbench

//  Sequences LDM/STM block transfers into single-register micro-ops, one per unstalled cycle.

---
 rtl/block_xfer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_block_xfer_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/block_xfer_sequencer.sv
// rtl/block_xfer_sequencer.sv - expands LDM/STM register lists into one micro-op per unstalled cycle
module block_xfer_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        inbubble,
  input  logic [31:0] insn,
  input  logic [31:0] inpc,
  input  logic [31:0] rn_val,
  output logic        outstall,
  output logic        outbubble,
  output logic [31:0] outpc,
  output logic [31:0] outinsn,
  output logic        outuop,
  output logic [3:0]  outreg,
  output logic [31:0] outaddr,
  output logic        outload,
  output logic        outfirst,
  output logic        outlast,
  output logic        outwb,
  output logic [31:0] outwbdata
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [15:0] remaining, rem_next;
  logic        wb_en, wb_en_next;

  logic        bubble_next, uop_next, load_next, first_next, last_next, wb_next;
  logic [31:0] pc_next, insn_next, addr_next, wbdata_next;
  logic [3:0]  reg_next;

  logic        blk;
  logic [15:0] list, list_rest;
  logic [4:0]  n;
  logic [31:0] step_w, span, start_addr, wb_addr;
  logic        multi_left;

  function automatic logic [3:0] low_idx(input logic [15:0] v);
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) low_idx = i[3:0];
  endfunction

  assign blk        = !inbubble && (insn[27:25] == 3'b100);
  assign list       = insn[15:0];
  assign list_rest  = list & (list - 16'd1);
  assign step_w     = 32'(STEP);
  assign span       = {27'd0, n} * step_w;
  assign start_addr = insn[23] ? rn_val + (insn[24] ? step_w : 32'd0)
                               : rn_val - span + (insn[24] ? 32'd0 : step_w);
  assign wb_addr    = insn[23] ? rn_val + span : rn_val - span;
  // More than one register still queued means Issue must keep holding.
  assign multi_left = (remaining & (remaining - 16'd1)) != 16'd0;
  assign outstall   = stall || (state == RUN && multi_left);

  always_comb begin
    n = 5'd0;
    for (int i = 0; i < 16; i++)
      n = n + 5'(list[i]);
  end

  always_comb begin
    state_next  = state;
    rem_next    = remaining;
    wb_en_next  = wb_en;
    bubble_next = outbubble;
    pc_next     = outpc;
    insn_next   = outinsn;
    uop_next    = outuop;
    reg_next    = outreg;
    addr_next   = outaddr;
    load_next   = outload;
    first_next  = outfirst;
    last_next   = outlast;
    wb_next     = outwb;
    wbdata_next = outwbdata;
    if (flush) begin
      state_next  = IDLE;
      rem_next    = 16'd0;
      bubble_next = 1'b1;
      uop_next    = 1'b0;
      first_next  = 1'b0;
      last_next   = 1'b0;
      wb_next     = 1'b0;
    end else if (!stall) begin
      unique case (state)
        IDLE: begin
          pc_next     = inpc;
          insn_next   = insn;
          bubble_next = inbubble;
          uop_next    = 1'b0;
          first_next  = 1'b0;
          last_next   = 1'b0;
          wb_next     = 1'b0;
          if (blk) begin
            // An empty list degenerates to a bubble.
            bubble_next = (n == 5'd0);
            if (n != 5'd0) begin
              uop_next    = 1'b1;
              first_next  = 1'b1;
              reg_next    = low_idx(list);
              addr_next   = start_addr;
              load_next   = insn[20];
              wb_en_next  = insn[21];
              wbdata_next = wb_addr;
              rem_next    = list_rest;
              if (list_rest != 16'd0) begin
                state_next = RUN;
              end else begin
                last_next = 1'b1;
                wb_next   = insn[21];
              end
            end
          end
        end
        RUN: begin
          reg_next   = low_idx(remaining);
          rem_next   = remaining & (remaining - 16'd1);
          addr_next  = outaddr + step_w;
          first_next = 1'b0;
          last_next  = !multi_left;
          wb_next    = wb_en && !multi_left;
          if (!multi_left) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= 16'd0;
      wb_en     <= 1'b0;
      outbubble <= 1'b1;
      outpc     <= 32'd0;
      outinsn   <= 32'd0;
      outuop    <= 1'b0;
      outreg    <= 4'd0;
      outaddr   <= 32'd0;
      outload   <= 1'b0;
      outfirst  <= 1'b0;
      outlast   <= 1'b0;
      outwb     <= 1'b0;
      outwbdata <= 32'd0;
    end else begin
      state     <= state_next;
      remaining <= rem_next;
      wb_en     <= wb_en_next;
      outbubble <= bubble_next;
      outpc     <= pc_next;
      outinsn   <= insn_next;
      outuop    <= uop_next;
      outreg    <= reg_next;
      outaddr   <= addr_next;
      outload   <= load_next;
      outfirst  <= first_next;
      outlast   <= last_next;
      outwb     <= wb_next;
      outwbdata <= wbdata_next;
    end
  end

endmodule

// File: tb/tb_block_xfer_sequencer.sv
// tb/tb_block_xfer_sequencer.sv - directed bench for block_xfer_sequencer
module tb_block_xfer_sequencer;

  logic        clk, rst, stall, flush, inbubble;
  logic [31:0] insn, inpc, rn_val;
  logic        outstall, outbubble, outuop, outload, outfirst, outlast, outwb;
  logic [31:0] outpc, outinsn, outaddr, outwbdata;
  logic [3:0]  outreg;

  int total  = 0;
  int passed = 0;

  block_xfer_sequencer #(.STEP(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inbubble(inbubble),
    .insn(insn), .inpc(inpc), .rn_val(rn_val), .outstall(outstall),
    .outbubble(outbubble), .outpc(outpc), .outinsn(outinsn), .outuop(outuop),
    .outreg(outreg), .outaddr(outaddr), .outload(outload), .outfirst(outfirst),
    .outlast(outlast), .outwb(outwb), .outwbdata(outwbdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // control bits packed as {bubble, uop, first, last, wb, reg}
  task automatic chk_uop(input string tag, input logic [3:0] r, input logic [31:0] a,
                         input logic f, input logic l, input logic w);
    chk({tag, "_ctl"}, {23'd0, outbubble, outuop, outfirst, outlast, outwb, outreg},
        {23'd0, 1'b0, 1'b1, f, l, w, r});
    chk({tag, "_addr"}, outaddr, a);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic b, input logic [31:0] i, input logic [31:0] pc, input logic [31:0] rn);
    inbubble = b;
    insn     = i;
    inpc     = pc;
    rn_val   = rn;
  endtask

  task automatic idle;
    drv(1'b1, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bubble", {31'd0, outbubble}, 32'd1);
    chk("rst_uop", {31'd0, outuop}, 32'd0);
    chk("rst_addr", outaddr, 32'd0);
    chk("rst_stall", {31'd0, outstall}, 32'd0);
    rst = 1'b0;

    // LDMIA r0!,{r1,r3,r15}
    drv(1'b0, 32'hE8B0_800A, 32'h100, 32'h1000);
    tick(); idle();
    chk_uop("t1u1", 4'd1, 32'h1000, 1'b1, 1'b0, 1'b0);
    chk("t1_stall_hi", {31'd0, outstall}, 32'd1);
    tick();
    chk_uop("t1u2", 4'd3, 32'h1004, 1'b0, 1'b0, 1'b0);
    chk("t1_stall_lo", {31'd0, outstall}, 32'd0);
    tick();
    chk_uop("t1u3", 4'd15, 32'h1008, 1'b0, 1'b1, 1'b1);
    chk("t1_wbdata", outwbdata, 32'h100C);
    chk("t1_load", {31'd0, outload}, 32'd1);
    chk("t1_pc", outpc, 32'h100);

    // STMDB r13!,{r4,r5}
    drv(1'b0, 32'hE92D_0030, 32'h104, 32'h2000);
    chk("t2_idle_stall", {31'd0, outstall}, 32'd0);
    tick(); idle();
    chk_uop("t2u1", 4'd4, 32'h1FF8, 1'b1, 1'b0, 1'b0);
    chk("t2_load", {31'd0, outload}, 32'd0);
    chk("t2_stall", {31'd0, outstall}, 32'd0);
    tick();
    chk_uop("t2u2", 4'd5, 32'h1FFC, 1'b0, 1'b1, 1'b1);
    chk("t2_wbdata", outwbdata, 32'h1FF8);

    // LDMIB r2,{r7} base 0
    drv(1'b0, 32'hE992_0080, 32'h108, 32'h0);
    tick(); idle();
    chk_uop("t2s", 4'd7, 32'h4, 1'b1, 1'b1, 1'b0);
    tick();
    chk("t2_after_bubble", {31'd0, outbubble}, 32'd1);

    // LDMDA r1!,{r0,r2,r4,r6} with stall after micro-op 2
    drv(1'b0, 32'hE831_0055, 32'h10C, 32'h3000);
    tick(); idle();
    chk_uop("t3u1", 4'd0, 32'h2FF4, 1'b1, 1'b0, 1'b0);
    tick();
    chk_uop("t3u2", 4'd2, 32'h2FF8, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_uop("t3frz", 4'd2, 32'h2FF8, 1'b0, 1'b0, 1'b0);
      chk("t3frz_stall", {31'd0, outstall}, 32'd1);
    end
    stall = 1'b0;
    tick();
    chk_uop("t3u3", 4'd4, 32'h2FFC, 1'b0, 1'b0, 1'b0);
    chk("t3_stall_lo", {31'd0, outstall}, 32'd0);
    tick();
    chk_uop("t3u4", 4'd6, 32'h3000, 1'b0, 1'b1, 1'b1);
    chk("t3_wbdata", outwbdata, 32'h2FF0);

    // flush after micro-op 1 of a 5-register list
    drv(1'b0, 32'hE890_001F, 32'h110, 32'h100);
    tick(); idle();
    chk_uop("t4u1", 4'd0, 32'h100, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_ctl", {29'd0, outbubble, outuop, outwb}, 32'b100);
    chk("t4_flush_stall", {31'd0, outstall}, 32'd0);
    drv(1'b0, 32'hE082_1003, 32'h200, 32'h0);
    tick(); idle();
    chk("t4_add_ctl", {30'd0, outbubble, outuop}, 32'b00);
    chk("t4_add_insn", outinsn, 32'hE082_1003);
    chk("t4_add_pc", outpc, 32'h200);

    // flush together with stall
    drv(1'b0, 32'hE890_001F, 32'h204, 32'h100);
    tick(); idle();
    chk_uop("t4b_u1", 4'd0, 32'h100, 1'b1, 1'b0, 1'b0);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("t4b_flush_ctl", {30'd0, outbubble, outuop}, 32'b10);

    // asynchronous reset mid-sequence
    drv(1'b0, 32'hE890_001F, 32'h208, 32'h100);
    tick(); idle();
    tick();
    chk_uop("t4c_u2", 4'd1, 32'h104, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("t4c_rst_ctl", {30'd0, outbubble, outuop}, 32'b10);
    chk("t4c_rst_reg", {28'd0, outreg}, 32'd0);
    chk("t4c_rst_addr", outaddr, 32'd0);
    chk("t4c_rst_stall", {31'd0, outstall}, 32'd0);
    rst = 1'b0;

    // empty list is a bubble
    drv(1'b0, 32'hE890_0000, 32'h300, 32'h100);
    chk("t5_empty_stall_pre", {31'd0, outstall}, 32'd0);
    tick(); idle();
    chk("t5_empty_ctl", {30'd0, outbubble, outuop}, 32'b10);
    chk("t5_empty_stall", {31'd0, outstall}, 32'd0);
    drv(1'b0, 32'hE082_1003, 32'h304, 32'h0);
    tick(); idle();
    chk("t5_add_ctl", {30'd0, outbubble, outuop}, 32'b00);
    chk("t5_add_pc", outpc, 32'h304);

    // LDMDA r0!,{r0-r3} base 4 wraps below zero
    drv(1'b0, 32'hE830_000F, 32'h308, 32'h4);
    tick(); idle();
    chk_uop("t5w1", 4'd0, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    tick();
    chk_uop("t5w2", 4'd1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    tick();
    chk_uop("t5w3", 4'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_uop("t5w4", 4'd3, 32'h4, 1'b0, 1'b1, 1'b1);
    chk("t5_wbdata", outwbdata, 32'hFFFF_FFF4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
